// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard/sequencing controller for the 5-stage vector pipeline. It sits
//   beside decode and produces stop/flush controls for PC, IF/ID and ID/EX.
//   It also sequences multi-cycle vector ALU ops held in EX.
//   Stall causes: load-use hazards, taken branches, multi-cycle EX ops and
//   an external memory stall.
//   Control outputs are combinational from state+inputs and forced to 0
//   while reset is low.
// Parameters
//   MULTI_CYCLES : EX occupancy of a multi-cycle vector op (>=1)
//   LOAD_LAT     : bubbles inserted per load-use hazard (>=1)
// Configuration macro
//   HAZARD_PERF_EN : when defined, stall_cnt/flush_cnt are live saturating
//                    counters cleared by perf_clr. Otherwise they are tied 0.
// Ports
//   clk, reset                 : clock (rising edge), async active-low reset
//   id_rs1/id_rs2, id_use1/2   : ID source registers and read-enables
//   ex_rd, ex_regWrite         : EX destination and write flag
//   ex_resultSrc               : EX instruction is a load
//   ex_multi, ex_branch_taken  : EX multi-cycle op / resolved-taken branch
//   ext_stall                  : memory not ready, freeze everything
//   perf_clr                   : synchronous perf counter clear
//   pc_stop, if_id_stop, id_ex_stop, if_id_flush, id_ex_flush,
//   ex_mem_bubble, alu_start, alu_done : pipeline controls
//   stall_cnt, flush_cnt       : perf counters
module pipeline_hazard_ctrl #(
  parameter int MULTI_CYCLES = 4,
  parameter int LOAD_LAT     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [3:0]  ex_rd,
  input  logic        ex_regWrite,
  input  logic        ex_resultSrc,
  input  logic        ex_multi,
  input  logic        ex_branch_taken,
  input  logic        ext_stall,
  input  logic        perf_clr,
  output logic        pc_stop,
  output logic        if_id_stop,
  output logic        id_ex_stop,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        alu_start,
  output logic        alu_done,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  localparam int MAXC = (MULTI_CYCLES > LOAD_LAT) ? MULTI_CYCLES : LOAD_LAT;
  localparam int CW   = $clog2(MAXC + 1);
  // The start cycle is spent in RUN, so the countdown begins at N-2.
  localparam logic [CW-1:0] MC_INIT = CW'((MULTI_CYCLES >= 2) ? MULTI_CYCLES - 2 : 0);
  localparam logic [CW-1:0] LL_INIT = CW'((LOAD_LAT >= 2) ? LOAD_LAT - 2 : 0);

  typedef enum logic [1:0] {RUN, LSTALL, MULTI} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            load_use;
  logic            br_flush;

  assign load_use = ex_resultSrc & ex_regWrite &
                    ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_stop       = 1'b0;
    if_id_stop    = 1'b0;
    id_ex_stop    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    alu_start     = 1'b0;
    alu_done      = 1'b0;
    br_flush      = 1'b0;
    if (!reset) begin
      // all controls low while in reset
    end else if (ext_stall) begin
      // freeze: state and cnt hold
      pc_stop    = 1'b1;
      if_id_stop = 1'b1;
      id_ex_stop = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
          end else if (ex_multi) begin
            alu_start = 1'b1;
            if (MULTI_CYCLES == 1) begin
              alu_done = 1'b1;
            end else begin
              pc_stop       = 1'b1;
              if_id_stop    = 1'b1;
              id_ex_stop    = 1'b1;
              ex_mem_bubble = 1'b1;
              cnt_nxt       = MC_INIT;
              state_nxt     = MULTI;
            end
          end else if (load_use) begin
            pc_stop     = 1'b1;
            if_id_stop  = 1'b1;
            id_ex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_nxt   = LL_INIT;
              state_nxt = LSTALL;
            end
          end
        end
        MULTI: begin
          // last EX cycle releases the pipe in the same cycle as alu_done
          if (cnt == '0) begin
            alu_done  = 1'b1;
            state_nxt = RUN;
          end else begin
            pc_stop       = 1'b1;
            if_id_stop    = 1'b1;
            id_ex_stop    = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_nxt       = cnt - 1'b1;
          end
        end
        LSTALL: begin
          pc_stop     = 1'b1;
          if_id_stop  = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counters; clear takes precedence over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (perf_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stop  && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (br_flush && (flush_q != '1)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic perf_unused;
  assign perf_unused = perf_clr ^ br_flush;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule
